mimo_channel_tx: RTL

- Transmit-side counterpart of the QR MIMO detector: forms the 2x2 complex received vector Y = H·X from a channel matrix H and a symbol vector X.
- Output Y drives the detector's Y inputs, and H is shared with the detector, giving closed-loop encode/detect checking in the same top level.
- Uses one time-multiplexed complex multiply-accumulate (four real multipliers), sequenced by an FSM with a start/valid handshake.

---
 rtl/mimo_channel_tx.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mimo_channel_tx.sv
// mimo_channel_tx: forms the 2x2 complex received vector Y = H*X.
// One complex multiply-accumulate is time-shared over four CALC cycles.
// The result is rounded half-up, saturated to Q2.13 and registered.
module mimo_channel_tx #(
    parameter int SZ   = 16,
    parameter int FRAC = 13
) (
    input  logic          CLK_100MHZ,
    input  logic          rst_n,
    input  logic          start,
    input  logic [SZ-1:0] H1R,
    input  logic [SZ-1:0] H1I,
    input  logic [SZ-1:0] H2R,
    input  logic [SZ-1:0] H2I,
    input  logic [SZ-1:0] H3R,
    input  logic [SZ-1:0] H3I,
    input  logic [SZ-1:0] H4R,
    input  logic [SZ-1:0] H4I,
    input  logic [SZ-1:0] X1R,
    input  logic [SZ-1:0] X1I,
    input  logic [SZ-1:0] X2R,
    input  logic [SZ-1:0] X2I,
    output logic [SZ-1:0] Y1R,
    output logic [SZ-1:0] Y1I,
    output logic [SZ-1:0] Y2R,
    output logic [SZ-1:0] Y2I,
    output logic          busy,
    output logic          valid
);

    localparam int AW = 2*SZ + 2;
    localparam logic signed [AW-1:0] MAXV = AW'((2**(SZ-1)) - 1);
    localparam logic signed [AW-1:0] MINV = ~MAXV;
    localparam logic signed [AW-1:0] RND  = AW'(2**(FRAC-1));

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    state_t state_q, state_d;
    logic [1:0] k;

    logic signed [SZ-1:0] hr_q [4];
    logic signed [SZ-1:0] hi_q [4];
    logic signed [SZ-1:0] xr_q [2];
    logic signed [SZ-1:0] xi_q [2];

    logic signed [AW-1:0] acc1r, acc1i, acc2r, acc2i;

    logic signed [SZ-1:0]   ar, ai, br, bi;
    logic signed [2*SZ-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [AW-1:0]   prod_r, prod_i;

    // Round half-up to FRAC fewer fractional bits, then clamp to SZ bits.
    function automatic logic [SZ-1:0] round_sat(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] r;
        r = (v + RND) >>> FRAC;
        if (r > MAXV)
            return MAXV[SZ-1:0];
        else if (r < MINV)
            return MINV[SZ-1:0];
        else
            return r[SZ-1:0];
    endfunction

    // Operand select: step k uses H(k+1); X1 for even k, X2 for odd k.
    always_comb begin
        ar     = hr_q[k];
        ai     = hi_q[k];
        br     = xr_q[k[0]];
        bi     = xi_q[k[0]];
        p_rr   = (2*SZ)'(ar) * (2*SZ)'(br);
        p_ii   = (2*SZ)'(ai) * (2*SZ)'(bi);
        p_ri   = (2*SZ)'(ar) * (2*SZ)'(bi);
        p_ir   = (2*SZ)'(ai) * (2*SZ)'(br);
        prod_r = AW'(p_rr) - AW'(p_ii);
        prod_i = AW'(p_ri) + AW'(p_ir);
    end

    // FSM state register.
    always_ff @(posedge CLK_100MHZ or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (k == 2'd3) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, MAC sequencing and result/handshake registers.
    always_ff @(posedge CLK_100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                hr_q[i] <= '0;
                hi_q[i] <= '0;
            end
            for (int unsigned i = 0; i < 2; i++) begin
                xr_q[i] <= '0;
                xi_q[i] <= '0;
            end
            k     <= '0;
            acc1r <= '0;
            acc1i <= '0;
            acc2r <= '0;
            acc2i <= '0;
            Y1R   <= '0;
            Y1I   <= '0;
            Y2R   <= '0;
            Y2I   <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        hr_q[0] <= H1R; hi_q[0] <= H1I;
                        hr_q[1] <= H2R; hi_q[1] <= H2I;
                        hr_q[2] <= H3R; hi_q[2] <= H3I;
                        hr_q[3] <= H4R; hi_q[3] <= H4I;
                        xr_q[0] <= X1R; xi_q[0] <= X1I;
                        xr_q[1] <= X2R; xi_q[1] <= X2I;
                        k       <= '0;
                        busy    <= 1'b1;
                    end
                end
                CALC: begin
                    k <= k + 2'd1;
                    case (k)
                        2'd0: begin acc1r <= prod_r;         acc1i <= prod_i;         end
                        2'd1: begin acc1r <= acc1r + prod_r; acc1i <= acc1i + prod_i; end
                        2'd2: begin acc2r <= prod_r;         acc2i <= prod_i;         end
                        default: begin acc2r <= acc2r + prod_r; acc2i <= acc2i + prod_i; end
                    endcase
                end
                OUT: begin
                    Y1R   <= round_sat(acc1r);
                    Y1I   <= round_sat(acc1i);
                    Y2R   <= round_sat(acc2r);
                    Y2I   <= round_sat(acc2i);
                    valid <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
